div_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one iterative 32-bit divider (start/ready handshake) between NUM_REQ requesters.
- Accepts one division at a time, launches it on the divider and supervises completion with a watchdog.
- Returns quotient/remainder to the granted requester over a valid/ready response channel.
- Divide-by-zero is resolved locally without invoking the divider.

---
 rtl/div_arb_pkg.sv | 21 ++
 rtl/div_arbiter_rr_arbiter.sv | 31 +++
 rtl/div_arbiter.sv | 137 +++++++++++++
 tb/tb_div_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  // Quotient reported for x/0; sliced down to the instance WIDTH (<= 64).
  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = {MAX_WIDTH{1'b1}};

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int               sum_s;
  logic [IDX_W-1:0] idx_s;

  // Scan offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    grant_idx = {IDX_W{1'b0}};
    any       = 1'b0;
    sum_s     = 0;
    idx_s     = {IDX_W{1'b0}};
    for (int off = NUM_REQ; off >= 1; off--) begin
      sum_s     = int'(last_grant) + off;
      idx_s     = IDX_W'((sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s);
      grant_idx = req[idx_s] ? idx_s : grant_idx;
      any       = any | req[idx_s];
    end
    grant = any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : {NUM_REQ{1'b0}};
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between NUM_REQ requesters: accept, launch,
// watchdog the divider, and return the result over a valid/ready channel.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic [1:0]               rsp_error,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  output logic                     div_abort,
  input  logic                     div_ready,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  // Abort is registered, so the decision is taken one cycle before it shows,
  // landing the pulse exactly DIV_TIMEOUT cycles after div_start.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV_TIMEOUT);

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   last_grant_r, grant_idx_r, arb_idx_s;
  logic [NUM_REQ-1:0] arb_grant_s, grant_hot_s;
  logic               arb_any_s, accept_s, rsp_hs_s, timeout_s, div0_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sel_dividend_s, sel_divisor_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .grant_idx  (arb_idx_s),
    .any        (arb_any_s)
  );

  assign sel_dividend_s = req_dividend[arb_idx_s*WIDTH +: WIDTH];
  assign sel_divisor_s  = req_divisor[arb_idx_s*WIDTH +: WIDTH];
  assign div0_s         = (sel_divisor_s == {WIDTH{1'b0}});
  assign accept_s       = (state_r == IDLE) && arb_any_s;
  assign rsp_hs_s       = (state_r == RESPOND) && rsp_ready[grant_idx_r];
  assign timeout_s      = (state_r == WAIT) && !div_ready && (cnt_r == CNT_LAST);
  assign grant_hot_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_r;
  // Gated by reset_n so every output reads 0 while reset is held.
  assign req_ready      = (state_r == IDLE && reset_n) ? arb_grant_s : {NUM_REQ{1'b0}};

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = accept_s ? (div0_s ? RESPOND : ISSUE) : IDLE;
      ISSUE:   state_s = WAIT;
      WAIT:    state_s = (div_ready || timeout_s) ? RESPOND : WAIT;
      RESPOND: state_s = rsp_hs_s ? IDLE : RESPOND;
      default: state_s = IDLE;
    endcase
  end

  // State register plus the registered datapath and output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      last_grant_r  <= IDX_W'(NUM_REQ - 1);
      grant_idx_r   <= {IDX_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      rsp_valid     <= {NUM_REQ{1'b0}};
      rsp_quotient  <= {WIDTH{1'b0}};
      rsp_remainder <= {WIDTH{1'b0}};
      rsp_error     <= ERR_OK;
      div_start     <= 1'b0;
      div_abort     <= 1'b0;
      div_dividend  <= {WIDTH{1'b0}};
      div_divisor   <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      div_start <= 1'b0;
      div_abort <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            grant_idx_r  <= arb_idx_s;
            div_dividend <= sel_dividend_s;
            div_divisor  <= sel_divisor_s;
            if (div0_s) begin
              rsp_valid     <= arb_grant_s;
              rsp_quotient  <= DIV0_QUOTIENT[WIDTH-1:0];
              rsp_remainder <= sel_dividend_s;
              rsp_error     <= ERR_DIV0;
            end else begin
              div_start <= 1'b1;
            end
          end
        end
        ISSUE: cnt_r <= {CNT_W{1'b0}};
        WAIT: begin
          if (div_ready) begin
            rsp_valid     <= grant_hot_s;
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_error     <= ERR_OK;
          end else if (timeout_s) begin
            div_abort     <= 1'b1;
            rsp_valid     <= grant_hot_s;
            rsp_quotient  <= {WIDTH{1'b0}};
            rsp_remainder <= {WIDTH{1'b0}};
            rsp_error     <= ERR_TIMEOUT;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESPOND: begin
          if (rsp_hs_s) begin
            rsp_valid    <= {NUM_REQ{1'b0}};
            last_grant_r <= grant_idx_r;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider model.
module tb_div_arbiter;
  localparam int N = 4, W = 32, TO = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [W-1:0] rsp_quotient, rsp_remainder, div_dividend, div_divisor, div_quotient, div_remainder;
  logic [1:0] rsp_error;
  logic div_start, div_abort, div_ready;
  logic m_ready, stray;
  logic [W-1:0] m_q, m_r, m_a, m_b;

  assign div_ready     = m_ready | stray;
  assign div_quotient  = stray ? 32'd99 : m_q;
  assign div_remainder = stray ? 32'd98 : m_r;

  div_arbiter #(.NUM_REQ(N), .WIDTH(W), .DIV_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_error(rsp_error), .div_start(div_start), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_abort(div_abort), .div_ready(div_ready),
    .div_quotient(div_quotient), .div_remainder(div_remainder));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;
  int starts = 0, aborts = 0, last_start_cyc = 0, last_abort_cyc = 0;
  int m_delay = 1, m_cnt = 0;
  bit m_never = 1'b0, m_active = 1'b0;

  // Divider model: answers m_delay cycles after div_start unless m_never.
  always @(negedge clk) begin
    m_ready = 1'b0;
    if (!reset_n) begin
      m_active = 1'b0;
    end else begin
      if (div_abort) begin aborts++; last_abort_cyc = cyc; m_active = 1'b0; end
      if (div_start) begin
        starts++; last_start_cyc = cyc;
        m_active = !m_never; m_cnt = m_delay; m_a = div_dividend; m_b = div_divisor;
      end else if (m_active) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ready = 1'b1; m_q = m_a / m_b; m_r = m_a % m_b; m_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic send(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int t;
    t = 0;
    req_dividend[idx*W +: W] = a;
    req_divisor[idx*W +: W]  = b;
    req_valid[idx] = 1'b1;
    #1;
    while (!req_ready[idx] && t < 200) begin tick(); t++; end
    chk("accept_wait", 64'(t < 200), 64'd1);
    acc = cyc;
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic get_rsp(input int idx, output int rc, output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic [1:0] e, output logic [N-1:0] v);
    int t;
    logic old;
    t = 0;
    while (rsp_valid == '0 && t < 300) begin tick(); t++; end
    chk("rsp_wait", 64'(t < 300), 64'd1);
    rc = cyc; q = rsp_quotient; r = rsp_remainder; e = rsp_error; v = rsp_valid;
    old = rsp_ready[idx];
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready[idx] = old;
  endtask

  task automatic rr_step(input int e, input logic [W-1:0] q, input logic [W-1:0] r);
    int t;
    t = 0;
    while (req_ready == '0 && t < 100) begin tick(); t++; end
    chk("rr_grant", 64'(req_ready), 64'(1) << e);
    tick();
    req_valid[e] = 1'b0;
    t = 0;
    while (rsp_valid == '0 && t < 100) begin tick(); t++; end
    chk("rr_rsp_valid", 64'(rsp_valid), 64'(1) << e);
    chk("rr_q", 64'(rsp_quotient), 64'(q));
    chk("rr_r", 64'(rsp_remainder), 64'(r));
    tick();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, "_rsp_q"}, 64'(rsp_quotient), 64'd0);
    chk({name, "_rsp_r"}, 64'(rsp_remainder), 64'd0);
    chk({name, "_rsp_err"}, 64'(rsp_error), 64'd0);
    chk({name, "_pulses"}, 64'({div_start, div_abort}), 64'd0);
    chk({name, "_div_ops"}, {div_dividend, div_divisor}, 64'd0);
  endtask

  typedef struct {
    int idx; logic [W-1:0] a; logic [W-1:0] b; int dly; bit never;
    logic [W-1:0] q; logic [W-1:0] r; logic [1:0] e;
  } vec_t;
  vec_t vt[8];

  initial begin
    int acc, rc, s0, a0, exp_rc;
    logic [W-1:0] q, r;
    logic [1:0] e;
    logic [N-1:0] v;

    vt[0] = '{0, 32'd10,         32'd3,   5, 1'b0, 32'd3,         32'd1,  2'b00};
    vt[1] = '{1, 32'd42,         32'd0,   1, 1'b0, 32'hFFFFFFFF,  32'd42, 2'b01};
    vt[2] = '{2, 32'd100,        32'd7,   1, 1'b0, 32'd14,        32'd2,  2'b00};
    vt[3] = '{3, 32'd0,          32'd5,   2, 1'b0, 32'd0,         32'd0,  2'b00};
    vt[4] = '{0, 32'hFFFFFFFF,   32'd1,   3, 1'b0, 32'hFFFFFFFF,  32'd0,  2'b00};
    vt[5] = '{1, 32'd7,          32'd2,   1, 1'b1, 32'd0,         32'd0,  2'b10};
    vt[6] = '{2, 32'd9,          32'd3,   4, 1'b0, 32'd3,         32'd0,  2'b00};
    vt[7] = '{3, 32'd0,          32'd0,   1, 1'b0, 32'hFFFFFFFF,  32'd0,  2'b01};

    reset_n = 1'b0; stray = 1'b0; m_ready = 1'b0; m_q = '0; m_r = '0;
    req_valid = '0; rsp_ready = '0; req_dividend = '0; req_divisor = '0;
    tick(); tick();
    chk_zero("in_reset");
    reset_n = 1'b1;
    tick();
    chk_zero("after_reset");

    // Table-driven transactions with latency and pulse-count checks.
    for (int i = 0; i < 8; i++) begin
      m_delay = vt[i].dly; m_never = vt[i].never; s0 = starts; a0 = aborts;
      send(vt[i].idx, vt[i].a, vt[i].b, acc);
      get_rsp(vt[i].idx, rc, q, r, e, v);
      chk($sformatf("v%0d_q", i), 64'(q), 64'(vt[i].q));
      chk($sformatf("v%0d_r", i), 64'(r), 64'(vt[i].r));
      chk($sformatf("v%0d_err", i), 64'(e), 64'(vt[i].e));
      chk($sformatf("v%0d_rsp_valid", i), 64'(v), 64'(1) << vt[i].idx);
      chk($sformatf("v%0d_starts", i), 64'(starts - s0), (vt[i].b == 0) ? 64'd0 : 64'd1);
      chk($sformatf("v%0d_aborts", i), 64'(aborts - a0), vt[i].never ? 64'd1 : 64'd0);
      if (vt[i].b == 0) exp_rc = acc + 1;
      else if (vt[i].never) exp_rc = acc + 1 + TO;
      else exp_rc = acc + vt[i].dly + 2;
      chk($sformatf("v%0d_latency", i), 64'(rc - acc), 64'(exp_rc - acc));
      if (vt[i].never) chk("abort_delay", 64'(last_abort_cyc - last_start_cyc), 64'(TO));
    end

    // Round robin after reset: 0,1,2,3 then 0 before 2.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    m_never = 1'b0; m_delay = 3; rsp_ready = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_dividend[i*W +: W] = 32'd100;
      req_divisor[i*W +: W]  = 32'(i + 1);
    end
    req_valid = 4'hF;
    #1;
    rr_step(0, 32'd100, 32'd0);
    rr_step(1, 32'd50, 32'd0);
    rr_step(2, 32'd33, 32'd1);
    rr_step(3, 32'd25, 32'd0);
    req_valid = 4'b0101;
    #1;
    rr_step(0, 32'd100, 32'd0);
    rr_step(2, 32'd33, 32'd1);

    // Back-pressured response with a competing request and a stray div_ready.
    rsp_ready = '0; m_delay = 2;
    req_dividend[0*W +: W] = 32'd30; req_divisor[0*W +: W] = 32'd4;
    req_dividend[1*W +: W] = 32'd8;  req_divisor[1*W +: W] = 32'd2;
    req_valid = 4'b0011;
    #1;
    chk("hold_grant0", 64'(req_ready), 64'd1);
    tick();
    req_valid[0] = 1'b0;
    begin
      int t;
      t = 0;
      while (rsp_valid == '0 && t < 50) begin tick(); t++; end
    end
    s0 = starts;
    rsp_ready[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_q", 64'(rsp_quotient), 64'd7);
      chk("hold_r", 64'(rsp_remainder), 64'd2);
      chk("hold_err", 64'(rsp_error), 64'd0);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      stray = (j == 3);
      tick();
    end
    stray = 1'b0;
    chk("hold_no_start", 64'(starts - s0), 64'd0);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    send(1, 32'd8, 32'd2, acc);
    get_rsp(1, rc, q, r, e, v);
    chk("after_hold_q", 64'(q), 64'd4);
    chk("after_hold_valid", 64'(v), 64'd2);

    // Asynchronous reset while the divider is busy.
    m_never = 1'b1;
    send(0, 32'd100, 32'd7, acc);
    tick(); tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    req_dividend[3*W +: W] = 32'd50; req_divisor[3*W +: W] = 32'd5;
    req_valid = 4'b1001;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_reset_grant", 64'(req_ready), 64'd1);
    m_never = 1'b0; m_delay = 2;
    send(0, 32'd100, 32'd7, acc);
    get_rsp(0, rc, q, r, e, v);
    chk("post_reset_q0", 64'(q), 64'd14);
    chk("post_reset_r0", 64'(r), 64'd2);
    chk("post_reset_grant3", 64'(req_ready), 64'd8);
    send(3, 32'd50, 32'd5, acc);
    get_rsp(3, rc, q, r, e, v);
    chk("post_reset_q3", 64'(q), 64'd10);
    chk("post_reset_v3", 64'(v), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
